// File: rtl/osc_sample_ctrl_pkg.sv
// osc_sample_ctrl_pkg: controller state encoding and sample word sizing.
// OSC_SAMPLE_INDEX_EN widens each stored sample by the burst index.
package osc_sample_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RECORD, CAPTURE, GAP} state_t;
`ifdef OSC_SAMPLE_INDEX_EN
  localparam bit INDEX_EN = 1'b1;
`else
  localparam bit INDEX_EN = 1'b0;
`endif
  function automatic int sample_w(int sum_w, int cfg_w);
    return sum_w + (INDEX_EN ? cfg_w : 0);
  endfunction
endpackage

// File: rtl/osc_sample_ctrl_sample_fifo.sv
// osc_sample_ctrl_sample_fifo: single-clock FIFO, wrap-bit pointers; a write on full succeeds only alongside a read.
module osc_sample_ctrl_sample_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/osc_sample_ctrl.sv
// osc_sample_ctrl: drives RECORDING windows into the oscillator bank and queues each window sum for readout.
// OSC_SAMPLE_INDEX_EN: DATA = {burst index, sum}; otherwise DATA = sum.
module osc_sample_ctrl
  import osc_sample_ctrl_pkg::*;
#(
  parameter int COUNTER_LENGTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_LEN = 2,
  parameter int CFG_W = 16
) (
  input  logic                                      CLOCK,
  input  logic                                      RESET,
  input  logic                                      START,
  input  logic                                      STOP,
  input  logic [CFG_W-1:0]                          WINDOW_CYCLES,
  input  logic [CFG_W-1:0]                          NUM_SAMPLES,
  input  logic [COUNTER_LENGTH-1:0]                 OSC_SUM,
  output logic                                      RECORDING,
  output logic [sample_w(COUNTER_LENGTH, CFG_W)-1:0] DATA,
  output logic                                      VALID,
  input  logic                                      READY,
  output logic                                      BUSY,
  output logic                                      OVERFLOW,
  input  logic                                      CLEAR_OVF
);
  localparam int SW = sample_w(COUNTER_LENGTH, CFG_W);
  localparam int GW = $clog2(GAP_LEN + 2);
  state_t state;
  logic [CFG_W-1:0] win_cnt, win_last, num, cnt, cnt_inc;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] din;
  logic stop_pend, stop_now, done, push, pop, full, empty, ovf_set;
  assign push = state == CAPTURE;
  assign pop = READY && !empty;
  assign ovf_set = push && full && !pop;
  assign cnt_inc = cnt + 1'b1;
  assign stop_now = stop_pend || STOP;
  assign done = stop_now || (num != '0 && cnt_inc == num);
  assign VALID = !empty;
  // The sample counter doubles as the 0-based burst index; dropped captures still advance it.
`ifdef OSC_SAMPLE_INDEX_EN
  assign din = {cnt, OSC_SUM};
`else
  assign din = OSC_SUM;
`endif
  osc_sample_ctrl_sample_fifo #(.W(SW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLOCK), .rst_n(RESET), .wr(push), .din(din), .rd(READY),
    .dout(DATA), .full(full), .empty(empty)
  );
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      RECORDING <= 1'b0;
      BUSY <= 1'b0;
      OVERFLOW <= 1'b0;
      stop_pend <= 1'b0;
      win_cnt <= '0;
      win_last <= '0;
      num <= '0;
      cnt <= '0;
      gap_cnt <= '0;
    end else begin
      OVERFLOW <= ovf_set || (OVERFLOW && !CLEAR_OVF);
      if (STOP && state != IDLE) stop_pend <= 1'b1;
      unique case (state)
        IDLE: if (START) begin
          state <= RECORD;
          RECORDING <= 1'b1;
          BUSY <= 1'b1;
          win_cnt <= '0;
          cnt <= '0;
          win_last <= (WINDOW_CYCLES == '0) ? '0 : WINDOW_CYCLES - 1'b1;
          num <= NUM_SAMPLES;
        end
        RECORD: if (win_cnt == win_last) begin
          state <= CAPTURE;
          RECORDING <= 1'b0;
        end else win_cnt <= win_cnt + 1'b1;
        CAPTURE: begin
          cnt <= cnt_inc;
          if (done) begin
            state <= IDLE;
            BUSY <= 1'b0;
            stop_pend <= 1'b0;
          end else if (GAP_LEN == 0) begin
            state <= RECORD;
            RECORDING <= 1'b1;
            win_cnt <= '0;
          end else begin
            state <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: if (stop_now) begin
          state <= IDLE;
          BUSY <= 1'b0;
          stop_pend <= 1'b0;
        end else if (gap_cnt == GW'(GAP_LEN - 1)) begin
          state <= RECORD;
          RECORDING <= 1'b1;
          win_cnt <= '0;
        end else gap_cnt <= gap_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_osc_sample_ctrl.sv
// tb_osc_sample_ctrl: randomized bench with a behavioural bank and arithmetic expectations for osc_sample_ctrl.
`timescale 1ns/1ps
module tb_osc_sample_ctrl;
  localparam int CL = 16, DEPTH = 16, GAP = 2, CW = 16;
`ifdef OSC_SAMPLE_INDEX_EN
  localparam int DW = CL + CW;
`else
  localparam int DW = CL;
`endif
  logic CLOCK = 0, RESET = 0, START = 0, STOP = 0, READY = 0, CLEAR_OVF = 0;
  logic [CW-1:0] WINDOW_CYCLES = 0, NUM_SAMPLES = 0;
  logic [CL-1:0] OSC_SUM = 0;
  logic RECORDING, VALID, BUSY, OVERFLOW;
  logic [DW-1:0] DATA;
  int checks = 0, errors = 0;
  int step = 5;
  logic was_rec = 0;
  logic [DW-1:0] rx[$];
  int hi_q[$], lo_q[$];
  int hi_run = 0, lo_run = 0;
  bit seen_hi = 0, hold_v = 0;
  logic [DW-1:0] hold_d;

  osc_sample_ctrl #(.COUNTER_LENGTH(CL), .FIFO_DEPTH(DEPTH), .GAP_LEN(GAP), .CFG_W(CW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .STOP(STOP),
    .WINDOW_CYCLES(WINDOW_CYCLES), .NUM_SAMPLES(NUM_SAMPLES), .OSC_SUM(OSC_SUM),
    .RECORDING(RECORDING), .DATA(DATA), .VALID(VALID), .READY(READY),
    .BUSY(BUSY), .OVERFLOW(OVERFLOW), .CLEAR_OVF(CLEAR_OVF)
  );

  always #5 CLOCK = ~CLOCK;

  // Bank: accumulates while RECORDING, clears on the edge closing the first low cycle after a window.
  always @(posedge CLOCK) begin
    if (RECORDING) OSC_SUM <= OSC_SUM + CL'(step);
    else if (was_rec) OSC_SUM <= '0;
    was_rec <= RECORDING;
  end

  always @(negedge CLOCK) begin
    if (hold_v) begin
      checks++;
      if (!VALID || DATA !== hold_d) begin
        errors++;
        $display("FAIL hold: VALID=%b DATA=%h, required VALID=1 DATA=%h", VALID, DATA, hold_d);
      end
    end
    hold_v = VALID && !READY;
    hold_d = DATA;
    if (VALID && READY) rx.push_back(DATA);
    if (RECORDING) begin
      if (seen_hi && lo_run > 0) lo_q.push_back(lo_run);
      lo_run = 0;
      hi_run++;
      seen_hi = 1;
    end else begin
      if (hi_run > 0) hi_q.push_back(hi_run);
      hi_run = 0;
      if (BUSY && seen_hi) lo_run++;
    end
  end

  function automatic logic [DW-1:0] exp_word(int idx, int sum);
`ifdef OSC_SAMPLE_INDEX_EN
    return {CW'(idx), CL'(sum)};
`else
    return (idx >= 0) ? DW'(sum) : '0;
`endif
  endfunction

  task automatic clear_mon();
    rx.delete();
    hi_q.delete();
    lo_q.delete();
    hi_run = 0;
    lo_run = 0;
    seen_hi = 0;
  endtask

  task automatic start(int w, int n, int s);
    step = s;
    WINDOW_CYCLES = CW'(w);
    NUM_SAMPLES = CW'(n);
    clear_mon();
    START = 1;
    @(posedge CLOCK); #1;
    START = 0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (BUSY && n < 2000) begin
      @(posedge CLOCK); #1;
      n++;
    end
    checks++;
    if (BUSY) begin
      errors++;
      $display("FAIL %s idle: BUSY=1 after %0d cycles, required 0", tag, n);
    end
  endtask

  task automatic wait_windows(string tag, int k);
    int n = 0;
    while (hi_q.size() < k && n < 2000) begin
      @(posedge CLOCK); #1;
      n++;
    end
    checks++;
    if (hi_q.size() < k) begin
      errors++;
      $display("FAIL %s windows: saw %0d, required %0d", tag, hi_q.size(), k);
    end
  endtask

  task automatic wait_rec(string tag, logic v);
    int n = 0;
    while (RECORDING !== v && n < 200) begin
      @(posedge CLOCK); #1;
      n++;
    end
    checks++;
    if (RECORDING !== v) begin
      errors++;
      $display("FAIL %s rec: RECORDING=%b, required %b", tag, RECORDING, v);
    end
  endtask

  task automatic test_reset();
    RESET = 0;
    repeat (3) @(posedge CLOCK); #1;
    checks += 4;
    if (RECORDING !== 1'b0) begin errors++; $display("FAIL reset RECORDING: got %b, required 0", RECORDING); end
    if (VALID !== 1'b0) begin errors++; $display("FAIL reset VALID: got %b, required 0", VALID); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset BUSY: got %b, required 0", BUSY); end
    if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset OVERFLOW: got %b, required 0", OVERFLOW); end
    RESET = 1;
    @(posedge CLOCK); #1;
  endtask

  task automatic test_burst();
    for (int it = 0; it < 6; it++) begin
      int w = (it == 0) ? 8 : (it == 1) ? 0 : int'($urandom_range(0, 12));
      int n = (it == 0) ? 3 : (it == 1) ? 1 : int'($urandom_range(1, 4));
      int s = (it < 2) ? 5 : int'($urandom_range(1, 200));
      int wl = (w == 0) ? 1 : w;
      int cyc = 0;
      READY = 1;
      start(w, n, s);
      checks++;
      if (RECORDING !== 1'b1) begin errors++; $display("FAIL burst%0d latency: RECORDING=%b, required 1", it, RECORDING); end
      while (BUSY && cyc < 1000) begin
        if (it >= 2) READY = 1'($urandom_range(0, 1));
        @(posedge CLOCK); #1;
        cyc++;
      end
      READY = 1;
      repeat (8) @(posedge CLOCK);
      #1;
      checks += 4;
      if (cyc != n * wl + n + (n - 1) * GAP) begin errors++; $display("FAIL burst%0d busy_len: got %0d, required %0d", it, cyc, n * wl + n + (n - 1) * GAP); end
      if (rx.size() != n) begin errors++; $display("FAIL burst%0d count: got %0d, required %0d", it, rx.size(), n); end
      if (hi_q.size() != n) begin errors++; $display("FAIL burst%0d windows: got %0d, required %0d", it, hi_q.size(), n); end
      if (lo_q.size() != n - 1) begin errors++; $display("FAIL burst%0d gaps: got %0d, required %0d", it, lo_q.size(), n - 1); end
      foreach (rx[i]) begin
        checks++;
        if (rx[i] !== exp_word(i, s * wl)) begin errors++; $display("FAIL burst%0d data[%0d]: got %h, required %h", it, i, rx[i], exp_word(i, s * wl)); end
      end
      foreach (hi_q[i]) begin
        checks++;
        if (hi_q[i] != wl) begin errors++; $display("FAIL burst%0d win_len[%0d]: got %0d, required %0d", it, i, hi_q[i], wl); end
      end
      foreach (lo_q[i]) begin
        checks++;
        if (lo_q[i] != 1 + GAP) begin errors++; $display("FAIL burst%0d gap_len[%0d]: got %0d, required %0d", it, i, lo_q[i], 1 + GAP); end
      end
    end
  endtask

  task automatic test_overflow();
    READY = 0;
    start(8, 20, 5);
    wait_windows("ovf", 16);
    wait_rec("ovf", 1'b1);
    wait_rec("ovf", 1'b0);
    checks++;
    if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf early: OVERFLOW=%b before 17th capture, required 0", OVERFLOW); end
    @(posedge CLOCK); #1;
    checks++;
    if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf set: OVERFLOW=%b after 17th capture, required 1", OVERFLOW); end
    wait_rec("ovf", 1'b1);
    wait_rec("ovf", 1'b0);
    CLEAR_OVF = 1;
    @(posedge CLOCK); #1;
    CLEAR_OVF = 0;
    checks++;
    if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf clear_vs_set: OVERFLOW=%b, required 1", OVERFLOW); end
    wait_idle("ovf");
    checks += 3;
    if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf sticky: OVERFLOW=%b, required 1", OVERFLOW); end
    if (rx.size() != 0) begin errors++; $display("FAIL ovf held: popped %0d, required 0", rx.size()); end
    if (hi_q.size() != 20) begin errors++; $display("FAIL ovf windows: got %0d, required 20", hi_q.size()); end
    READY = 1;
    repeat (20) @(posedge CLOCK);
    #1;
    checks += 2;
    if (rx.size() != DEPTH) begin errors++; $display("FAIL ovf drain: got %0d, required %0d", rx.size(), DEPTH); end
    if (VALID !== 1'b0) begin errors++; $display("FAIL ovf empty: VALID=%b, required 0", VALID); end
    foreach (rx[i]) begin
      checks++;
      if (rx[i] !== exp_word(i, 40)) begin errors++; $display("FAIL ovf data[%0d]: got %h, required %h", i, rx[i], exp_word(i, 40)); end
    end
    CLEAR_OVF = 1;
    @(posedge CLOCK); #1;
    CLEAR_OVF = 0;
    checks++;
    if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf cleared: OVERFLOW=%b, required 0", OVERFLOW); end
  endtask

  task automatic test_full_pushpop();
    READY = 0;
    start(4, 17, 7);
    wait_windows("pp", 16);
    wait_rec("pp", 1'b1);
    wait_rec("pp", 1'b0);
    READY = 1;
    @(posedge CLOCK); #1;
    READY = 0;
    checks++;
    if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL pushpop overflow: OVERFLOW=%b, required 0", OVERFLOW); end
    wait_idle("pp");
    READY = 1;
    repeat (20) @(posedge CLOCK);
    #1;
    checks++;
    if (rx.size() != 17) begin errors++; $display("FAIL pushpop count: got %0d, required 17", rx.size()); end
    foreach (rx[i]) begin
      checks++;
      if (rx[i] !== exp_word(i, 28)) begin errors++; $display("FAIL pushpop data[%0d]: got %h, required %h", i, rx[i], exp_word(i, 28)); end
    end
  endtask

  task automatic test_stop();
    int w = int'($urandom_range(4, 9));
    READY = 1;
    start(w, 0, 5);
    wait_windows("stop_rec", 3);
    wait_rec("stop_rec", 1'b1);
    STOP = 1;
    @(posedge CLOCK); #1;
    STOP = 0;
    wait_idle("stop_rec");
    repeat (10) @(posedge CLOCK);
    #1;
    checks += 2;
    if (hi_q.size() != 4) begin errors++; $display("FAIL stop_rec windows: got %0d, required 4", hi_q.size()); end
    if (rx.size() != 4) begin errors++; $display("FAIL stop_rec count: got %0d, required 4", rx.size()); end
    foreach (rx[i]) begin
      checks++;
      if (rx[i] !== exp_word(i, 5 * w)) begin errors++; $display("FAIL stop_rec data[%0d]: got %h, required %h", i, rx[i], exp_word(i, 5 * w)); end
    end
    start(w, 0, 5);
    wait_windows("stop_gap", 2);
    STOP = 1;
    @(posedge CLOCK); #1;
    STOP = 0;
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL stop_gap busy: BUSY=%b, required 0", BUSY); end
    repeat (10) @(posedge CLOCK);
    #1;
    checks += 2;
    if (hi_q.size() != 2) begin errors++; $display("FAIL stop_gap windows: got %0d, required 2", hi_q.size()); end
    if (rx.size() != 2) begin errors++; $display("FAIL stop_gap count: got %0d, required 2", rx.size()); end
  endtask

  task automatic test_async_reset();
    int w = int'($urandom_range(1, 10));
    int wl;
    READY = 0;
    start(10, 0, 5);
    wait_windows("areset", 3);
    wait_rec("areset", 1'b1);
    checks++;
    if (VALID !== 1'b1) begin errors++; $display("FAIL areset queued: VALID=%b, required 1", VALID); end
    #2;
    RESET = 0;
    hold_v = 0;
    #1;
    checks += 4;
    if (RECORDING !== 1'b0) begin errors++; $display("FAIL areset RECORDING: got %b, required 0", RECORDING); end
    if (VALID !== 1'b0) begin errors++; $display("FAIL areset VALID: got %b, required 0", VALID); end
    if (BUSY !== 1'b0) begin errors++; $display("FAIL areset BUSY: got %b, required 0", BUSY); end
    if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL areset OVERFLOW: got %b, required 0", OVERFLOW); end
    @(posedge CLOCK); #1;
    RESET = 1;
    READY = 1;
    wl = w;
    start(w, 2, 9);
    wait_idle("areset");
    repeat (5) @(posedge CLOCK);
    #1;
    checks++;
    if (rx.size() != 2) begin errors++; $display("FAIL areset restart count: got %0d, required 2", rx.size()); end
    foreach (rx[i]) begin
      checks++;
      if (rx[i] !== exp_word(i, 9 * wl)) begin errors++; $display("FAIL areset restart data[%0d]: got %h, required %h", i, rx[i], exp_word(i, 9 * wl)); end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_overflow();
    test_full_pushpop();
    test_stop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/osc_sample_ctrl.md
Name: osc_sample_ctrl

Overview:
- Controller at the consuming end of the oscillator-bank interface: drives RECORDING windows of programmable length into the oscillator bank and captures the bank's accumulated sum at the end of each window.
- Buffers captured samples in an internal FIFO and presents them on a valid/ready stream toward the host/readout path.
- Supports single-burst (N samples) and continuous acquisition.

Parameters:
- COUNTER_LENGTH, 16, width of the bank sum and of each sample.
- FIFO_DEPTH, 16, sample FIFO entries; power of two, >=2.
- GAP_LEN, 2, idle cycles with RECORDING low between windows; 0 allowed.
- CFG_W, 16, width of WINDOW_CYCLES and NUM_SAMPLES.

Ports:
- CLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; begins acquisition from IDLE, ignored otherwise.
- STOP  in  1  one-cycle pulse; ends acquisition after the current capture.
- WINDOW_CYCLES  in  CFG_W  recording window length in cycles; latched at START; 0 treated as 1.
- NUM_SAMPLES  in  CFG_W  samples per burst; latched at START; 0 = continuous until STOP.
- OSC_SUM  in  COUNTER_LENGTH  accumulated sum from the oscillator bank.
- RECORDING  out  1  registered window enable to the bank.
- DATA  out  COUNTER_LENGTH (+CFG_W with option)  FIFO head sample.
- VALID  out  1  FIFO non-empty.
- READY  in  1  consumer accepts DATA when VALID&&READY.
- BUSY  out  1  high in any state other than IDLE.
- OVERFLOW  out  1  sticky; a capture was dropped because the FIFO was full.
- CLEAR_OVF  in  1  clears OVERFLOW.

Behaviour:
- Reset (RESET=0, async): state IDLE; RECORDING=0, VALID=0, BUSY=0, OVERFLOW=0; FIFO emptied; counters cleared. DATA don't-care while VALID=0.
- States: IDLE, RECORD, CAPTURE, GAP.
  - IDLE: on START, latch config, clear sample counter, go to RECORD.
  - RECORD: RECORDING=1 for exactly max(WINDOW_CYCLES,1) cycles, then CAPTURE.
  - CAPTURE: RECORDING=0 for one cycle. At the closing edge of this cycle, OSC_SUM still holds the full-window sum; the bank clears on that same edge. Push OSC_SUM into the FIFO and increment the sample count.
    - Go to IDLE if a stop is pending, or if NUM_SAMPLES!=0 and count==NUM_SAMPLES.
    - Otherwise go to GAP, or directly to RECORD if GAP_LEN=0.
  - GAP: RECORDING=0 for GAP_LEN cycles, then RECORD.
- Latency: START high at edge k gives RECORDING=1 from edge k+1. Sample visible with VALID=1 one cycle after the CAPTURE push edge.
- STOP: sets a pending flag.
  - In RECORD, the window completes and is captured before IDLE.
  - In GAP, go to IDLE immediately with no further window.
  - In IDLE, no effect.
  - The pending flag clears on entry to IDLE.
- START is ignored while BUSY.
- FIFO full at capture: sample dropped, OVERFLOW set, acquisition continues. Push and pop in the same cycle on a full FIFO: the pop frees the slot and the push succeeds, with no overflow.
- CLEAR_OVF and a new overflow in the same cycle: OVERFLOW stays 1.
- The sample counter and FIFO pointers wrap modulo their width. Continuous mode never terminates on count wrap.
- Window counter width is CFG_W. Sum width and overflow are the bank's concern; OSC_SUM is stored verbatim.
- DATA/VALID are stable while VALID&&!READY.

Optional Feature:
- Macro OSC_SAMPLE_INDEX_EN.
- Defined: DATA is {sample_index[CFG_W-1:0], sum}. Sample index is the 0-based index within the burst, wrapping. Dropped samples still consume an index, so gaps are visible to the host.
- Undefined: DATA is the sum only; no index storage.

Decomposition:
- Shared package: state enumeration (IDLE/RECORD/CAPTURE/GAP) and the sample word width derived from COUNTER_LENGTH, CFG_W and the macro.
- One sub-module, sample_fifo: synchronous single-clock FIFO with full/empty flags, parameterised by width and depth, same clock and async active-low reset.

Test Plan:
- Bank model adds 5 per RECORDING cycle; START, WINDOW_CYCLES=8, NUM_SAMPLES=3, GAP_LEN=2, READY=1 -> three samples of 40, RECORDING high 8 cycles then low 3 (CAPTURE + 2 GAP), BUSY low after third capture.
- WINDOW_CYCLES=0, NUM_SAMPLES=1 -> RECORDING high exactly 1 cycle, sample 5.
- READY=0, FIFO_DEPTH=16, NUM_SAMPLES=20 -> 16 samples held, OVERFLOW=1 after 17th capture. Then READY=1 -> 16 values of 40 drained in order, VALID then 0. CLEAR_OVF -> OVERFLOW=0.
- NUM_SAMPLES=0, STOP asserted mid-RECORD of the 4th window -> 4 samples total, IDLE after the 4th CAPTURE. STOP during GAP -> no further RECORDING pulse.
- RESET pulsed low mid-RECORD with 3 samples queued -> RECORDING, VALID, BUSY, OVERFLOW all 0 immediately (asynchronously); subsequent START works normally.
- With OSC_SAMPLE_INDEX_EN, NUM_SAMPLES=4, READY=0, FIFO_DEPTH=2 -> DATA indices 0,1 delivered; indices 2,3 dropped; OVERFLOW=1.
